flag_unit: RTL and testbench

FLAG_UNIT -- requirements
Module: flag_unit

---
 rtl/flag_unit_pkg.sv | 14 +
 rtl/flag_stack.sv | 62 ++++++
 rtl/flag_unit.sv | 103 ++++++++++
 tb/tb_flag_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/flag_unit_pkg.sv
// rtl/flag_unit_pkg.sv - op encodings, NZCV bit positions and flags type shared with condition evaluation
package flag_unit_pkg;
  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOGIC = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flags_t;
endpackage

// File: rtl/flag_stack.sv
// rtl/flag_stack.sv - DEPTH x 4-bit LIFO for saved flags with full/empty and sticky misuse error
module flag_stack
  import flag_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [3:0] wr_flags,
  output logic [3:0] rd_flags,
  output logic       pop_ok,
  output logic       full,
  output logic       empty,
  output logic       err
);
  localparam int PW = $clog2(DEPTH + 1);

  logic [PW-1:0] ptr;
  flags_t        mem [DEPTH];
  logic          push_ok;
  logic          bad;

  assign full    = (ptr == PW'(DEPTH));
  assign empty   = (ptr == '0);
  assign push_ok = push && !pop && !full;
  assign pop_ok  = pop && !push && !empty;
  assign bad     = (push && pop) || (push && full) || (pop && empty);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
      err <= 1'b0;
    end else begin
      if (push_ok)
        ptr <= ptr + PW'(1);
      else if (pop_ok)
        ptr <= ptr - PW'(1);
      if (bad)
        err <= 1'b1;
    end
  end

  // Storage is not reset; the pointer alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (rst_n && push_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ptr == PW'(i))
          mem[i] <= wr_flags;
      end
    end
  end

  always_comb begin
    rd_flags = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ptr == PW'(i + 1))
        rd_flags = mem[i];
    end
  end
endmodule

// File: rtl/flag_unit.sv
// rtl/flag_unit.sv - NZCV flag register with ADD/SUB/LOGIC/LOAD updates; save stack under FLAG_UNIT_STACK_EN
module flag_unit
  import flag_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_res,
  input  logic [3:0]       in_flags,
  input  logic             set_en,
  input  logic             exec,
  input  logic             push,
  input  logic             pop,
  output logic [3:0]       flags,
  output logic             flags_upd,
  output logic             stk_full,
  output logic             stk_empty,
  output logic             stk_err
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  flags_t         nxt;
  flags_t         stk_top;
  logic           stk_pop_ok;
  logic           upd;

  assign sum  = {1'b0, in_a} + {1'b0, in_b};
  assign diff = {1'b0, in_a} + {1'b0, ~in_b} + {{WIDTH{1'b0}}, 1'b1};
  assign upd  = in_valid && in_ready && set_en && exec;

  always_comb begin
    nxt = flags;
    case (op)
      OP_ADD: begin
        nxt[FLAG_N] = sum[WIDTH-1];
        nxt[FLAG_Z] = (sum[WIDTH-1:0] == '0);
        nxt[FLAG_C] = sum[WIDTH];
        nxt[FLAG_V] = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        nxt[FLAG_N] = diff[WIDTH-1];
        nxt[FLAG_Z] = (diff[WIDTH-1:0] == '0);
        nxt[FLAG_C] = diff[WIDTH];
        nxt[FLAG_V] = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_LOGIC: begin
        nxt[FLAG_N] = in_res[WIDTH-1];
        nxt[FLAG_Z] = (in_res == '0);
      end
      default: nxt = in_flags;
    endcase
  end

`ifdef FLAG_UNIT_STACK_EN
  // A pop owns the flags register for its cycle, so requests are held off.
  assign in_ready = !pop;

  flag_stack #(.DEPTH(DEPTH)) u_stack (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .wr_flags (flags),
    .rd_flags (stk_top),
    .pop_ok   (stk_pop_ok),
    .full     (stk_full),
    .empty    (stk_empty),
    .err      (stk_err)
  );
`else
  logic unused_stack_ctl;

  assign in_ready         = 1'b1;
  assign stk_full         = 1'b0;
  assign stk_empty        = 1'b1;
  assign stk_err          = 1'b0;
  assign stk_pop_ok       = 1'b0;
  assign stk_top          = '0;
  assign unused_stack_ctl = push ^ pop;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags     <= '0;
      flags_upd <= 1'b0;
    end else if (stk_pop_ok) begin
      flags     <= stk_top;
      flags_upd <= 1'b1;
    end else if (upd) begin
      flags     <= nxt;
      flags_upd <= 1'b1;
    end else begin
      flags_upd <= 1'b0;
    end
  end
endmodule

// File: tb/tb_flag_unit.sv
// tb/tb_flag_unit.sv - directed scoreboard bench for flag_unit; covers both FLAG_UNIT_STACK_EN builds
module tb_flag_unit;
  localparam int W     = 32;
  localparam int DEPTH = 4;
`ifdef FLAG_UNIT_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] in_a, in_b, in_res;
  logic [3:0]   in_flags;
  logic         set_en, exec, push, pop;
  logic [3:0]   flags;
  logic         flags_upd, stk_full, stk_empty, stk_err;

  typedef struct {
    logic [3:0] fl;
    logic       upd;
    logic       full;
    logic       empty;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] m_stk[$];
  logic [3:0] m_flags;
  logic       m_err;
  int         checks   = 0;
  int         failures = 0;

  flag_unit #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .in_a(in_a), .in_b(in_b), .in_res(in_res), .in_flags(in_flags),
    .set_en(set_en), .exec(exec), .push(push), .pop(pop),
    .flags(flags), .flags_upd(flags_upd),
    .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference flags from signed-range overflow and unsigned magnitude compare.
  function automatic logic [3:0] model(input logic [1:0] o, input logic [W-1:0] a, b, r,
                                       input logic [3:0] f, cur);
    longint          sa, sb_, s;
    longint unsigned ua, ub;
    logic [W-1:0]    res;
    logic            c, v;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (o)
      2'b00: begin
        s = sa + sb_; res = a + b; c = (ua + ub) > 64'hFFFF_FFFF;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return {res[W-1], res == 0, c, v};
      end
      2'b01: begin
        s = sa - sb_; res = a - b; c = (ua >= ub);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return {res[W-1], res == 0, c, v};
      end
      2'b10:   return {r[W-1], r == 0, cur[1:0]};
      default: return f;
    endcase
  endfunction

  task automatic idle();
    in_valid = 1'b0; op = 2'b00; in_a = '0; in_b = '0; in_res = '0; in_flags = '0;
    set_en = 1'b0; exec = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  task automatic step(input logic [1:0] o, input logic [W-1:0] a, b, r, input logic [3:0] f,
                      input logic s, e, ps, pp, v);
    logic rdy, u, pop_ok, eu;
    logic [3:0] pv;
    exp_t ex;
    in_valid = v; op = o; in_a = a; in_b = b; in_res = r; in_flags = f;
    set_en = s; exec = e; push = ps; pop = pp;
    rdy = STK ? !pp : 1'b1;
    u = v && rdy && s && e;
    pop_ok = 1'b0;
    pv = '0;
    if (STK) begin
      if (ps && pp) m_err = 1'b1;
      else if (ps) begin
        if (m_stk.size() == DEPTH) m_err = 1'b1;
        else m_stk.push_back(m_flags);
      end else if (pp) begin
        if (m_stk.size() == 0) m_err = 1'b1;
        else begin pop_ok = 1'b1; pv = m_stk.pop_back(); end
      end
    end
    eu = 1'b1;
    if (pop_ok) m_flags = pv;
    else if (u) m_flags = model(o, a, b, r, f, m_flags);
    else eu = 1'b0;
    sb.push_back('{m_flags, eu, m_stk.size() == DEPTH, m_stk.size() == 0, m_err});
    #1;
    chk("in_ready", in_ready, rdy);
    @(posedge clk);
    #1;
    ex = sb.pop_front();
    chk("flags", flags, ex.fl);
    chk("flags_upd", flags_upd, ex.upd);
    chk("stk_full", stk_full, ex.full);
    chk("stk_empty", stk_empty, ex.empty);
    chk("stk_err", stk_err, ex.err);
    idle();
  endtask

  task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, b, r, input logic [3:0] f,
                       input logic e);
    step(o, a, b, r, f, 1'b1, e, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    in_valid = 1'b1; op = 2'b11; in_flags = 4'hF; set_en = 1'b1; exec = 1'b1;
    push = 1'b1; pop = 1'b1; rst_n = 1'b0;
    m_flags = '0; m_err = 1'b0; m_stk.delete();
    sb.push_back('{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0});
    @(posedge clk);
    #1;
    begin
      exp_t ex;
      ex = sb.pop_front();
      chk("rst_flags", flags, ex.fl);
      chk("rst_upd", flags_upd, ex.upd);
      chk("rst_full", stk_full, ex.full);
      chk("rst_empty", stk_empty, ex.empty);
      chk("rst_err", stk_err, ex.err);
    end
    idle();
    rst_n = 1'b1;
    #1;
    chk("rst_ready", in_ready, 1'b1);
  endtask

  initial begin
    idle();
    do_reset();

    do_op(2'b00, 32'h7FFF_FFFF, 32'h1, '0, '0, 1'b1);
    chk("add_ovf", flags, 4'b1001);
    chk("add_ovf_upd", flags_upd, 1'b1);
    do_op(2'b01, 32'd5, 32'd5, '0, '0, 1'b1);
    chk("sub_eq", flags, 4'b0110);
    do_op(2'b01, 32'd3, 32'd5, '0, '0, 1'b1);
    chk("sub_lt", flags, 4'b1000);
    do_op(2'b11, '0, '0, '0, 4'b0011, 1'b1);
    do_op(2'b10, '0, '0, 32'h0, '0, 1'b1);
    chk("logic_z", flags, 4'b0111);
    do_op(2'b10, '0, '0, 32'h8000_0000, '0, 1'b0);
    chk("squash", flags, 4'b0111);
    chk("squash_upd", flags_upd, 1'b0);
    step(2'b11, '0, '0, '0, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(2'b11, '0, '0, '0, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op(2'b00, 32'hFFFF_FFFF, 32'h1, '0, '0, 1'b1);
    chk("add_wrap", flags, 4'b0110);
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, '0, '0, 1'b1);
    chk("add_negovf", flags, 4'b0111);
    do_op(2'b01, 32'h8000_0000, 32'h1, '0, '0, 1'b1);
    chk("sub_ovf", flags, 4'b0011);
    for (int i = 0; i < 12; i++)
      do_op(2'($urandom_range(0, 2)), $urandom, $urandom, $urandom, 4'($urandom), 1'b1);

`ifdef FLAG_UNIT_STACK_EN
    do_op(2'b11, '0, '0, '0, 4'b1010, 1'b1);
    step(2'b01, 32'd5, 32'd5, '0, '0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("push_sub", flags, 4'b0110);
    step(2'b11, '0, '0, '0, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("pop_restore", flags, 4'b1010);
    chk("pop_upd", flags_upd, 1'b1);

    for (int i = 0; i <= DEPTH; i++) begin
      do_op(2'b11, '0, '0, '0, 4'(i + 3), 1'b1);
      step(2'b00, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk("deep_full", stk_full, 1'b1);
    chk("deep_err", stk_err, 1'b1);
    for (int i = 0; i <= DEPTH; i++)
      step(2'b00, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("deep_empty", stk_empty, 1'b1);
    chk("deep_err_sticky", stk_err, 1'b1);
    chk("deep_lifo_last", flags, 4'd3);

    do_reset();
    step(2'b00, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("collide_empty", stk_empty, 1'b1);
    chk("collide_err", stk_err, 1'b1);
    do_op(2'b11, '0, '0, '0, 4'b1100, 1'b1);
    step(2'b00, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    do_reset();
`else
    step(2'b11, '0, '0, '0, 4'b0101, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(2'b11, '0, '0, '0, 4'b1010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("nostk_pop_ignored", flags, 4'b1010);
    step(2'b00, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    do_reset();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
